// File: rtl/diag_pkg.sv
// diag_pkg: shared width, fold constant, fail codes and FSM states for the diagonal checker
package diag_pkg;
    localparam int W = 4;
    localparam logic [W-1:0] KMAX = {W{1'b1}};
    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_PROP = 2'b01;
    localparam logic [1:0] FC_STEP = 2'b10;
    localparam logic [1:0] FC_BOTH = 2'b11;
    typedef enum logic [1:0] {IDLE, TRACK, FAIL} state_t;
endpackage

// File: rtl/diag_succ.sv
// diag_succ: combinational successor function of the diagonal walker
module diag_succ
    import diag_pkg::*;
(
    input  logic [W-1:0] px,
    input  logic [W-1:0] py,
    input  logic         pf,
    output logic [W-1:0] nx,
    output logic [W-1:0] ny
);
    logic fold;
    always_comb begin
        fold = pf && px > py;
        nx = fold ? (KMAX >> 1) + (px >> 1) :
             px < py ? px :
             (px == py || px != KMAX) ? px + 1'b1 : py;
        ny = fold ? py : (px <= py || px != KMAX) ? py + 1'b1 : px;
    end
endmodule

// File: rtl/diagonal_checker.sv
// diagonal_checker: checks a walker (x, y) stream for legal steps and x >= y, latching the first failure
module diagonal_checker
    import diag_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    input  logic [W-1:0]  in_y,
    input  logic          in_fold,
    input  logic          clear,
    output logic          prop_ok,
    output logic          step_ok,
    output logic          fail,
    output logic [1:0]    fail_code,
    output logic [W-1:0]  fail_x,
    output logic [W-1:0]  fail_y,
    output logic [CW-1:0] sample_cnt
);
    state_t state, state_n;
    logic [W-1:0] px, py, nx, ny;
    logic pf, acc, p_ok, s_ok, bad;

    diag_succ u_succ (.px(px), .py(py), .pf(pf), .nx(nx), .ny(ny));

    // clear beats a same-cycle sample, so it never counts as accepted
    always_comb begin
        in_ready = state != FAIL;
        acc = in_valid && in_ready && !clear;
        p_ok = in_x >= in_y;
        s_ok = state == IDLE || (in_x == nx && in_y == ny);
        bad = !p_ok || !s_ok;
        state_n = clear ? IDLE : !acc ? state : bad ? FAIL : TRACK;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            prop_ok <= 1'b1;
            step_ok <= 1'b1;
            fail <= 1'b0;
            fail_code <= FC_NONE;
            fail_x <= '0;
            fail_y <= '0;
            sample_cnt <= '0;
            px <= '0;
            py <= '0;
            pf <= 1'b0;
        end else begin
            state <= state_n;
            if (clear) begin
                fail <= 1'b0;
                fail_code <= FC_NONE;
                sample_cnt <= '0;
            end else if (acc) begin
                prop_ok <= p_ok;
                step_ok <= s_ok;
                sample_cnt <= &sample_cnt ? sample_cnt : sample_cnt + 1'b1;
                if (bad) begin
                    fail <= 1'b1;
                    fail_code <= !p_ok ? (s_ok ? FC_PROP : FC_BOTH) : FC_STEP;
                    fail_x <= in_x;
                    fail_y <= in_y;
                end else begin
                    px <= in_x;
                    py <= in_y;
                    pf <= in_fold;
                end
            end
        end
    end
endmodule

// File: tb/tb_diagonal_checker.sv
// tb_diagonal_checker: directed and random stream checks of diagonal_checker against a behavioural model
module tb_diagonal_checker;
    localparam int CW = 4;
    localparam int KM = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0, in_fold = 1'b0, clear = 1'b0;
    logic [3:0] in_x = '0, in_y = '0;
    logic in_ready, prop_ok, step_ok, fail;
    logic [1:0] fail_code;
    logic [3:0] fail_x, fail_y;
    logic [CW-1:0] sample_cnt;

    int n_chk = 0;
    int n_fail = 0;

    int m_cnt, m_fx, m_fy, m_px, m_py;
    bit m_prop, m_step, m_fail, m_track, m_pf;
    int m_code;

    diagonal_checker #(.CW(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_fold(in_fold), .clear(clear),
        .prop_ok(prop_ok), .step_ok(step_ok), .fail(fail), .fail_code(fail_code),
        .fail_x(fail_x), .fail_y(fail_y), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    function automatic int sx(int px, int py, int pf);
        if (pf != 0 && px > py) return KM / 2 + px / 2;
        if (px < py) return px;
        if (px == py || px != KM) return (px + 1) % 16;
        return py;
    endfunction

    function automatic int sy(int px, int py, int pf);
        if (pf != 0 && px > py) return py;
        if (px <= py || px != KM) return (py + 1) % 16;
        return px;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), 32'(!m_fail));
        chk("prop_ok", 32'(prop_ok), 32'(m_prop));
        chk("step_ok", 32'(step_ok), 32'(m_step));
        chk("fail", 32'(fail), 32'(m_fail));
        chk("fail_code", 32'(fail_code), 32'(m_code));
        chk("fail_x", 32'(fail_x), 32'(m_fx));
        chk("fail_y", 32'(fail_y), 32'(m_fy));
        chk("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_cnt = 0; m_fx = 0; m_fy = 0; m_px = 0; m_py = 0; m_code = 0;
        m_prop = 1; m_step = 1; m_fail = 0; m_track = 0; m_pf = 0;
    endtask

    task automatic step(input bit v, input int x, input int y, input bit f, input bit clr);
        bit p, s;
        in_valid = v; in_x = 4'(x); in_y = 4'(y); in_fold = f; clear = clr;
        @(posedge clk);
        if (clr) begin
            m_track = 0; m_fail = 0; m_code = 0; m_cnt = 0;
        end else if (v && !m_fail) begin
            p = x >= y;
            s = !m_track || (x == sx(m_px, m_py, m_pf) && y == sy(m_px, m_py, m_pf));
            m_prop = p; m_step = s;
            if (m_cnt < 2**CW - 1) m_cnt++;
            if (!p || !s) begin
                m_fail = 1; m_code = (s ? 0 : 2) + (p ? 0 : 1); m_fx = x; m_fy = y;
            end else begin
                m_px = x; m_py = y; m_pf = f; m_track = 1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle_x();
        in_valid = 1'b0; in_x = 'x; in_y = 'x; in_fold = 1'bx; clear = 1'b0;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic legal(input bit f);
        step(1, sx(m_px, m_py, m_pf), sy(m_px, m_py, m_pf), f, 0);
    endtask

    initial begin
        int r, x, y;
        reset = 1'b0; in_valid = 1'b1; in_x = 4'd5; in_y = 4'd9;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        check_all();
        reset = 1'b1;

        step(1, 1, 0, 0, 0);
        step(1, 2, 1, 0, 0);
        step(1, 3, 2, 0, 0);
        chk("stream_cnt", 32'(sample_cnt), 32'd3);

        step(0, 0, 0, 0, 1);
        step(1, 6, 2, 1, 0);
        step(1, 10, 2, 0, 0);
        chk("fold_legal", 32'(step_ok), 32'd1);
        step(0, 0, 0, 0, 1);
        step(1, 6, 2, 1, 0);
        step(1, 11, 2, 0, 0);
        chk("fold_bad_code", 32'(fail_code), 32'd2);
        step(1, 12, 3, 0, 0);
        chk("fail_blocks", 32'(in_ready), 32'd0);

        step(0, 0, 0, 0, 1);
        step(1, 3, 3, 0, 0);
        step(1, 4, 4, 0, 0);
        step(1, 2, 5, 0, 0);
        chk("both_code", 32'(fail_code), 32'd3);

        step(0, 0, 0, 0, 1);
        step(1, 15, 4, 0, 0);
        step(1, 4, 15, 0, 0);
        chk("kmax_code", 32'(fail_code), 32'd1);
        chk("kmax_step", 32'(step_ok), 32'd1);

        step(1, 7, 1, 0, 1);
        chk("clear_cnt", 32'(sample_cnt), 32'd0);
        step(1, 9, 2, 0, 0);
        chk("idle_prop_only", 32'(fail), 32'd0);
        idle_x();

        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 1, 0);
        repeat (18) legal(1);
        chk("cnt_saturate", 32'(sample_cnt), 32'(2**CW - 1));

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            x = $urandom_range(0, 15);
            y = $urandom_range(0, 15);
            if (m_fail) begin
                if (r < 40) step($urandom_range(0, 1), x, y, 0, 1);
                else step(1, x, y, $urandom_range(0, 1), 0);
            end else if (r < 5) step(1, x, y, 0, 1);
            else if (r < 15) idle_x();
            else if (!m_track) step(1, x > y ? x : y, x > y ? y : x, $urandom_range(0, 1), 0);
            else if (r < 85) legal($urandom_range(0, 1));
            else step(1, x, y, $urandom_range(0, 1), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
